// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: on a go edge, walks the descriptor table in order and hands each live
// descriptor to the streamer. Optional busy-cycle counter under `DMA_SCHED_PERF_CNT_EN`.

module dma_desc_sched #(
    parameter  int NUM_DESC    = 2,
    parameter  int ADDR_WIDTH  = 32,
    parameter  int BYTES_WIDTH = 32,
    localparam int IDX_W       = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          go_i,
    input  logic                          abort_i,
    input  logic [NUM_DESC-1:0]           desc_en_i,
    input  logic [NUM_DESC*ADDR_WIDTH-1:0]  desc_src_i,
    input  logic [NUM_DESC*ADDR_WIDTH-1:0]  desc_dst_i,
    input  logic [NUM_DESC*BYTES_WIDTH-1:0] desc_bytes_i,
    input  logic [NUM_DESC-1:0]           desc_wr_mode_i,
    input  logic [NUM_DESC-1:0]           desc_rd_mode_i,
    output logic                          xfer_valid_o,
    input  logic                          xfer_ready_i,
    output logic [ADDR_WIDTH-1:0]         xfer_src_o,
    output logic [ADDR_WIDTH-1:0]         xfer_dst_o,
    output logic [BYTES_WIDTH-1:0]        xfer_bytes_o,
    output logic                          xfer_wr_mode_o,
    output logic                          xfer_rd_mode_o,
    output logic [IDX_W-1:0]              xfer_idx_o,
    input  logic                          xfer_done_i,
    input  logic                          xfer_err_i,
    output logic                          flush_o,
    input  logic                          flush_ack_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
`ifdef DMA_SCHED_PERF_CNT_EN
    output logic [31:0]                   perf_cycles_o,
`endif
    output logic [IDX_W-1:0]              err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DISPATCH,
        S_WAIT,
        S_FLUSH,
        S_FINISH
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             go_q;
    logic             go_start;
    logic             idx_last;
    logic             load_fields;
    logic             set_err;

    logic                   desc_en_sel;
    logic [ADDR_WIDTH-1:0]  desc_src_sel;
    logic [ADDR_WIDTH-1:0]  desc_dst_sel;
    logic [BYTES_WIDTH-1:0] desc_bytes_sel;
    logic                   desc_wr_sel;
    logic                   desc_rd_sel;
    logic                   desc_hit;

    // Only the descriptor under the scan pointer is ever looked at.
    assign desc_en_sel    = desc_en_i[idx];
    assign desc_src_sel   = desc_src_i[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign desc_dst_sel   = desc_dst_i[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign desc_bytes_sel = desc_bytes_i[int'(idx)*BYTES_WIDTH +: BYTES_WIDTH];
    assign desc_wr_sel    = desc_wr_mode_i[idx];
    assign desc_rd_sel    = desc_rd_mode_i[idx];
    assign desc_hit       = desc_en_sel && (desc_bytes_sel != '0);

    assign idx_last = (idx == IDX_W'(NUM_DESC - 1));
    assign go_start = (state == S_IDLE) && go_i && !go_q;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which keeps this block purely combinational instead of inferring latches.
    always_comb begin
        next_state  = state;
        idx_next    = idx;
        load_fields = 1'b0;
        set_err     = 1'b0;

        case (state)
            S_IDLE: begin
                if (go_start) begin
                    next_state = S_SCAN;
                    idx_next   = '0;
                end
            end

            S_SCAN: begin
                if (abort_i) begin
                    next_state = S_FLUSH;
                end else if (desc_hit) begin
                    next_state  = S_DISPATCH;
                    load_fields = 1'b1;
                end else if (idx_last) begin
                    next_state = S_FINISH;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end

            S_DISPATCH: begin
                // Abort wins even over a same-cycle handshake.
                if (abort_i) begin
                    next_state = S_FLUSH;
                end else if (xfer_ready_i) begin
                    next_state = S_WAIT;
                end
            end

            S_WAIT: begin
                set_err = xfer_err_i;
                if (abort_i || xfer_err_i) begin
                    next_state = S_FLUSH;
                end else if (xfer_done_i) begin
                    if (idx_last) begin
                        next_state = S_FINISH;
                    end else begin
                        next_state = S_SCAN;
                        idx_next   = idx + 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                if (flush_ack_i) begin
                    next_state = S_FINISH;
                end
            end

            S_FINISH: begin
                next_state = S_IDLE;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state and outputs are all updated with non-blocking assignments so every
    // register samples pre-edge values; reset is synchronous and clears every output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            go_q           <= 1'b0;
            xfer_valid_o   <= 1'b0;
            xfer_src_o     <= '0;
            xfer_dst_o     <= '0;
            xfer_bytes_o   <= '0;
            xfer_wr_mode_o <= 1'b0;
            xfer_rd_mode_o <= 1'b0;
            xfer_idx_o     <= '0;
            flush_o        <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            err_idx_o      <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            go_q  <= go_i;

            // Outputs are registered off the next state so they line up with it.
            xfer_valid_o <= (next_state == S_DISPATCH);
            flush_o      <= (next_state == S_FLUSH);
            busy_o       <= (next_state != S_IDLE);

            if (load_fields) begin
                xfer_src_o     <= desc_src_sel;
                xfer_dst_o     <= desc_dst_sel;
                xfer_bytes_o   <= desc_bytes_sel;
                xfer_wr_mode_o <= desc_wr_sel;
                xfer_rd_mode_o <= desc_rd_sel;
                xfer_idx_o     <= idx;
            end

            if (go_start) begin
                done_o  <= 1'b0;
                error_o <= 1'b0;
            end

            if (state == S_FINISH) begin
                done_o <= 1'b1;
            end

            if (set_err) begin
                error_o   <= 1'b1;
                err_idx_o <= idx;
            end
        end
    end

`ifdef DMA_SCHED_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (go_start) begin
            perf_cnt <= '0;
        end else if (busy_o && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cnt;
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// Self-checking bench for dma_desc_sched: streamer/flush responder plus a table-driven
// reference of which descriptors must be dispatched, in what order and when.

module tb_dma_desc_sched;

    localparam int ND = 2;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int IW = 1;
    localparam int FW = 2*AW + BW + 2 + IW;

    logic              clk;
    logic              rst_n;
    logic              go_i;
    logic              abort_i;
    logic [ND-1:0]     desc_en_i;
    logic [ND*AW-1:0]  desc_src_i;
    logic [ND*AW-1:0]  desc_dst_i;
    logic [ND*BW-1:0]  desc_bytes_i;
    logic [ND-1:0]     desc_wr_mode_i;
    logic [ND-1:0]     desc_rd_mode_i;
    logic              xfer_valid_o;
    logic              xfer_ready_i;
    logic [AW-1:0]     xfer_src_o;
    logic [AW-1:0]     xfer_dst_o;
    logic [BW-1:0]     xfer_bytes_o;
    logic              xfer_wr_mode_o;
    logic              xfer_rd_mode_o;
    logic [IW-1:0]     xfer_idx_o;
    logic              xfer_done_i;
    logic              xfer_err_i;
    logic              flush_o;
    logic              flush_ack_i;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [IW-1:0]     err_idx_o;
`ifdef DMA_SCHED_PERF_CNT_EN
    logic [31:0]       perf_cycles_o;
`endif

    dma_desc_sched #(
        .NUM_DESC   (ND),
        .ADDR_WIDTH (AW),
        .BYTES_WIDTH(BW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go_i          (go_i),
        .abort_i       (abort_i),
        .desc_en_i     (desc_en_i),
        .desc_src_i    (desc_src_i),
        .desc_dst_i    (desc_dst_i),
        .desc_bytes_i  (desc_bytes_i),
        .desc_wr_mode_i(desc_wr_mode_i),
        .desc_rd_mode_i(desc_rd_mode_i),
        .xfer_valid_o  (xfer_valid_o),
        .xfer_ready_i  (xfer_ready_i),
        .xfer_src_o    (xfer_src_o),
        .xfer_dst_o    (xfer_dst_o),
        .xfer_bytes_o  (xfer_bytes_o),
        .xfer_wr_mode_o(xfer_wr_mode_o),
        .xfer_rd_mode_o(xfer_rd_mode_o),
        .xfer_idx_o    (xfer_idx_o),
        .xfer_done_i   (xfer_done_i),
        .xfer_err_i    (xfer_err_i),
        .flush_o       (flush_o),
        .flush_ack_i   (flush_ack_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
`ifdef DMA_SCHED_PERF_CNT_EN
        .perf_cycles_o (perf_cycles_o),
`endif
        .err_idx_o     (err_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] f;
        int            cyc;
    } hs_t;

    int  checks;
    int  errors;
    int  cyc;
    hs_t hs_q[$];

    // Streamer model knobs
    int  ready_pct;
    int  done_dly;
    int  flush_dly;
    int  pend_cyc;
    bit  err_arm;
    int  flush_run;
    int  flush_total;
    int  busy_total;
    int  valid_total;
    bit  prev_stall;
    logic [FW-1:0] prev_f;

    // Descriptor table as the CSRs would hold it
    logic          t_en[ND];
    logic [AW-1:0] t_src[ND];
    logic [AW-1:0] t_dst[ND];
    logic [BW-1:0] t_bytes[ND];
    logic          t_wr[ND];
    logic          t_rd[ND];

    function automatic logic [FW-1:0] exp_fields(input int i);
        return {t_src[i], t_dst[i], t_bytes[i], t_wr[i], t_rd[i], IW'(i)};
    endfunction

    task automatic set_table();
        for (int i = 0; i < ND; i++) begin
            desc_en_i[i]                 = t_en[i];
            desc_src_i[i*AW +: AW]       = t_src[i];
            desc_dst_i[i*AW +: AW]       = t_dst[i];
            desc_bytes_i[i*BW +: BW]     = t_bytes[i];
            desc_wr_mode_i[i]            = t_wr[i];
            desc_rd_mode_i[i]            = t_rd[i];
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then drive the streamer side.
    task automatic step();
        logic [FW-1:0] cur_f;
        @(posedge clk);
        #1;
        cyc++;
        xfer_done_i = 1'b0;
        xfer_err_i  = 1'b0;
        if (pend_cyc == cyc) begin
            xfer_done_i = 1'b1;
            xfer_err_i  = err_arm;
            err_arm     = 1'b0;
            pend_cyc    = -1;
        end
        xfer_ready_i = ($urandom_range(99) < ready_pct);
        if (xfer_valid_o) valid_total++;
        if (busy_o) busy_total++;
        cur_f = {xfer_src_o, xfer_dst_o, xfer_bytes_o, xfer_wr_mode_o, xfer_rd_mode_o, xfer_idx_o};
        if (prev_stall && xfer_valid_o) begin
            checks++;
            if (cur_f !== prev_f) begin
                errors++;
                $display("FAIL stall_stable cyc %0d got %h exp %h", cyc, cur_f, prev_f);
            end
        end
        prev_stall = xfer_valid_o && !xfer_ready_i;
        prev_f     = cur_f;
        if (xfer_valid_o && xfer_ready_i) begin
            hs_q.push_back('{f: cur_f, cyc: cyc});
            pend_cyc = cyc + done_dly;
        end
        if (flush_o) begin
            flush_run++;
            flush_total++;
            pend_cyc    = -1;
            flush_ack_i = (flush_run >= flush_dly);
        end else begin
            flush_run   = 0;
            flush_ack_i = 1'b0;
        end
    endtask

    task automatic start_run(output int n);
        hs_q.delete();
        busy_total  = 0;
        valid_total = 0;
        flush_total = 0;
        go_i = 1'b1;
        n    = cyc;
        step();
        go_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_o === 1'b1) begin
                dc = cyc;
                break;
            end
            step();
        end
        checks++;
        if (dc < 0) begin
            errors++;
            $display("FAIL run_timeout got no done_o within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({xfer_valid_o, flush_o, busy_o, done_o, error_o, err_idx_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0",
                     {xfer_valid_o, flush_o, busy_o, done_o, error_o, err_idx_o});
        end
        checks++;
        if (prev_f !== '0) begin
            errors++;
            $display("FAIL reset_fields got %h exp 0", prev_f);
        end
        rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_go busy got %b exp 0", busy_o);
        end
    endtask

    task automatic load_plan_table();
        t_en[0] = 1'b1; t_src[0] = 32'h1000; t_dst[0] = 32'h2000; t_bytes[0] = 32'd64;
        t_wr[0] = 1'b0; t_rd[0] = 1'b0;
        t_en[1] = 1'b1; t_src[1] = 32'h3000; t_dst[1] = 32'h4000; t_bytes[1] = 32'd64;
        t_wr[1] = 1'b1; t_rd[1] = 1'b1;
        set_table();
    endtask

    task automatic test_two_desc();
        int n, dc;
        load_plan_table();
        ready_pct = 100; done_dly = 5; flush_dly = 1;
        start_run(n);
        wait_done(100, dc);
        checks++;
        if (hs_q.size() != 2) begin
            errors++;
            $display("FAIL two_desc_count got %0d exp 2", hs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (hs_q[k].f !== exp_fields(k)) begin
                    errors++;
                    $display("FAIL two_desc_fields%0d got %h exp %h", k, hs_q[k].f, exp_fields(k));
                end
            end
            checks++;
            if (hs_q[0].cyc != n + 2) begin
                errors++;
                $display("FAIL first_offer_cyc got %0d exp %0d", hs_q[0].cyc - n, 2);
            end
            checks++;
            if (hs_q[1].cyc != hs_q[0].cyc + 5 + 2) begin
                errors++;
                $display("FAIL second_offer_cyc got %0d exp %0d", hs_q[1].cyc - n, hs_q[0].cyc + 7 - n);
            end
            checks++;
            if (dc != hs_q[1].cyc + 5 + 2) begin
                errors++;
                $display("FAIL two_desc_done_cyc got %0d exp %0d", dc - n, hs_q[1].cyc + 7 - n);
            end
        end
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("FAIL two_desc_error got %b exp 0", error_o);
        end
`ifdef DMA_SCHED_PERF_CNT_EN
        checks++;
        if (perf_cycles_o !== 32'(busy_total)) begin
            errors++;
            $display("FAIL perf_cycles got %0d exp %0d", perf_cycles_o, busy_total);
        end
`endif
    endtask

    task automatic test_none_enabled();
        int n, dc;
        load_plan_table();
        t_en[0] = 1'b0; t_bytes[1] = '0;
        set_table();
        start_run(n);
        wait_done(50, dc);
        checks++;
        if (valid_total != 0) begin
            errors++;
            $display("FAIL none_valid got %0d cycles exp 0", valid_total);
        end
        checks++;
        if (dc != n + ND + 2) begin
            errors++;
            $display("FAIL none_done_cyc got %0d exp %0d", dc - n, ND + 2);
        end
    endtask

    task automatic test_err_done();
        int n, dc;
        load_plan_table();
        ready_pct = 100; done_dly = 5; flush_dly = 3;
        err_arm = 1'b1;
        start_run(n);
        wait_done(100, dc);
        checks++;
        if (hs_q.size() != 1) begin
            errors++;
            $display("FAIL err_count got %0d exp 1", hs_q.size());
        end else begin
            checks++;
            if (dc != hs_q[0].cyc + 5 + 5) begin
                errors++;
                $display("FAIL err_done_cyc got %0d exp %0d", dc - n, hs_q[0].cyc + 10 - n);
            end
        end
        checks++;
        if (flush_total != 3) begin
            errors++;
            $display("FAIL err_flush_cycles got %0d exp 3", flush_total);
        end
        checks++;
        if ({error_o, err_idx_o} !== {1'b1, IW'(0)}) begin
            errors++;
            $display("FAIL err_status got %b exp %b", {error_o, err_idx_o}, {1'b1, IW'(0)});
        end
        err_arm = 1'b0;
    endtask

    task automatic test_go_edges();
        int n, dc;
        load_plan_table();
        ready_pct = 100; done_dly = 5; flush_dly = 1;
        for (int r = 0; r < 2; r++) begin
            start_run(n);
            checks++;
            if ({busy_o, done_o, error_o} !== 3'b100) begin
                errors++;
                $display("FAIL go_clear%0d got %b exp 100", r, {busy_o, done_o, error_o});
            end
            if (r == 0) begin
                repeat (3) step();
                go_i = 1'b1;
                step();
                go_i = 1'b0;
            end
            wait_done(100, dc);
            checks++;
            if (hs_q.size() != 2 || dc != n + 16) begin
                errors++;
                $display("FAIL go_run%0d got %0d xfers done@%0d exp 2 xfers done@16",
                         r, hs_q.size(), dc - n);
            end
        end
    endtask

    task automatic test_abort();
        int n, dc;
        bit seen;
        load_plan_table();
        ready_pct = 0; done_dly = 5; flush_dly = 2;
        start_run(n);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (xfer_valid_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_offer got no xfer_valid_o exp offer");
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checks++;
        if ({xfer_valid_o, flush_o} !== 2'b01) begin
            errors++;
            $display("FAIL abort_drop got valid/flush %b exp 01", {xfer_valid_o, flush_o});
        end
        wait_done(50, dc);
        checks++;
        if ({error_o, hs_q.size() == 0} !== 2'b01) begin
            errors++;
            $display("FAIL abort_end got error %b xfers %0d exp 0 and 0", error_o, hs_q.size());
        end
        abort_i = 1'b1;
        repeat (2) step();
        abort_i = 1'b0;
        checks++;
        if ({busy_o, done_o, flush_o} !== 3'b010) begin
            errors++;
            $display("FAIL abort_idle got %b exp 010", {busy_o, done_o, flush_o});
        end
    endtask

    task automatic test_reset_mid_run();
        int n, dc;
        load_plan_table();
        ready_pct = 100; done_dly = 20; flush_dly = 1;
        start_run(n);
        for (int i = 0; i < 20 && hs_q.size() == 0; i++) step();
        step();
        rst_n    = 1'b0;
        go_i     = 1'b1;
        pend_cyc = -1;
        step();
        checks++;
        if ({xfer_valid_o, flush_o, busy_o, done_o, error_o, err_idx_o} !== '0 || prev_f !== '0) begin
            errors++;
            $display("FAIL reset_mid got ctrl %b fields %h exp 0",
                     {xfer_valid_o, flush_o, busy_o, done_o, error_o, err_idx_o}, prev_f);
        end
        step();
        hs_q.delete();
        rst_n = 1'b1;
        step();
        go_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL go_through_reset busy got %b exp 1", busy_o);
        end
        done_dly = 3;
        wait_done(100, dc);
        checks++;
        if (hs_q.size() != 2) begin
            errors++;
            $display("FAIL post_reset_count got %0d exp 2", hs_q.size());
        end
    endtask

    task automatic test_random();
        int n, dc;
        int exp_q[$];
        bit exp_err;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < ND; i++) begin
                t_en[i]    = 1'($urandom_range(1));
                t_src[i]   = $urandom;
                t_dst[i]   = $urandom;
                t_bytes[i] = ($urandom_range(3) == 0) ? '0 : $urandom;
                t_wr[i]    = 1'($urandom_range(1));
                t_rd[i]    = 1'($urandom_range(1));
            end
            set_table();
            ready_pct = $urandom_range(30, 100);
            done_dly  = $urandom_range(1, 6);
            flush_dly = $urandom_range(1, 4);
            err_arm   = ($urandom_range(3) == 0);
            exp_q.delete();
            for (int i = 0; i < ND; i++)
                if (t_en[i] && t_bytes[i] != '0) exp_q.push_back(i);
            exp_err = err_arm && (exp_q.size() > 0);
            if (exp_err) exp_q = exp_q[0:0];
            start_run(n);
            wait_done(300, dc);
            checks++;
            if (hs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d exp %0d", it, hs_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    checks++;
                    if (hs_q[k].f !== exp_fields(exp_q[k])) begin
                        errors++;
                        $display("FAIL rand%0d_fields%0d got %h exp %h",
                                 it, k, hs_q[k].f, exp_fields(exp_q[k]));
                    end
                end
            end
            checks++;
            if (error_o !== exp_err) begin
                errors++;
                $display("FAIL rand%0d_error got %b exp %b", it, error_o, exp_err);
            end
            if (exp_err) begin
                checks++;
                if (err_idx_o !== IW'(exp_q[0])) begin
                    errors++;
                    $display("FAIL rand%0d_err_idx got %0d exp %0d", it, err_idx_o, exp_q[0]);
                end
            end
            err_arm = 1'b0;
            step();
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; go_i = 1'b0; abort_i = 1'b0;
        desc_en_i = '0; desc_src_i = '0; desc_dst_i = '0; desc_bytes_i = '0;
        desc_wr_mode_i = '0; desc_rd_mode_i = '0;
        xfer_ready_i = 1'b0; xfer_done_i = 1'b0; xfer_err_i = 1'b0; flush_ack_i = 1'b0;
        ready_pct = 100; done_dly = 5; flush_dly = 1; pend_cyc = -1; err_arm = 1'b0;
        flush_run = 0; flush_total = 0; busy_total = 0; valid_total = 0;
        prev_stall = 1'b0; prev_f = '0;

        test_reset();
        test_two_desc();
        test_none_enabled();
        test_err_done();
        test_go_edges();
        test_abort();
        test_reset_mid_run();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
